// File: rtl/vpd_ctrl.sv
// VPD storage controller: captures one config-space read/write request, performs a
// single RAM access and reports completion with a done pulse plus at most one error flag.
module vpd_ctrl #(
    parameter int VPD_WORDS = 256,
    parameter int WP_WORDS  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [14:0] cfg_vpd_addr,
    input  logic        cfg_vpd_wren,
    input  logic [31:0] cfg_vpd_wdata,
    input  logic        cfg_vpd_rden,
    input  logic        vpd_wp_override,
    output logic [31:0] vpd_cfg_rdata,
    output logic        vpd_cfg_done,
    output logic        vpd_err_unimplemented_addr,
    output logic        vpd_err_write_protect,
    output logic        vpd_err_protocol,
    output logic        vpd_busy
);

    localparam int AW = (VPD_WORDS > 1) ? $clog2(VPD_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, WAIT_RELEASE} state_t;

    state_t      state;
    logic [12:0] idx_p0;
    logic [1:0]  off_p0;
    logic [31:0] wdata_p0;
    logic        rd_p0;
    logic        wr_p0;
    logic        ovr_p0;

    logic [31:0] mem [VPD_WORDS];

    logic implemented;
    logic wp_hit;
    logic proto_err;
    logic unimpl_err;
    logic wp_err;
    logic wr_commit;

    // Request capture: the access works only from these copies, so the requester
    // may change addr/wdata freely once the request has been taken.
    always_ff @(posedge clock) begin
        if (state == IDLE) begin
            idx_p0   <= cfg_vpd_addr[14:2];
            off_p0   <= cfg_vpd_addr[1:0];
            wdata_p0 <= cfg_vpd_wdata;
            rd_p0    <= cfg_vpd_rden;
            wr_p0    <= cfg_vpd_wren;
            ovr_p0   <= vpd_wp_override;
        end
    end

    always_comb begin
        implemented = (off_p0 == 2'b00) && ({1'b0, idx_p0} < 14'(VPD_WORDS));
        wp_hit      = {1'b0, idx_p0} < 14'(WP_WORDS);
        proto_err   = rd_p0 && wr_p0;
        unimpl_err  = !proto_err && !implemented;
        wp_err      = !proto_err && implemented && wr_p0 && wp_hit && !ovr_p0;
        wr_commit   = (state == ACCESS) && !reset && wr_p0 && !proto_err
                      && implemented && !wp_err;
    end

    // Access stage: the only cycle that touches storage.
    always_ff @(posedge clock) begin
        if (wr_commit)
            mem[idx_p0[AW-1:0]] <= wdata_p0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                      <= IDLE;
            vpd_cfg_rdata              <= '0;
            vpd_cfg_done               <= 1'b0;
            vpd_err_unimplemented_addr <= 1'b0;
            vpd_err_write_protect      <= 1'b0;
            vpd_err_protocol           <= 1'b0;
        end else begin
            vpd_cfg_done               <= 1'b0;
            vpd_err_unimplemented_addr <= 1'b0;
            vpd_err_write_protect      <= 1'b0;
            vpd_err_protocol           <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_vpd_rden || cfg_vpd_wren)
                        state <= ACCESS;
                end
                ACCESS: begin
                    state                      <= DONE;
                    vpd_cfg_done               <= 1'b1;
                    vpd_err_protocol           <= proto_err;
                    vpd_err_unimplemented_addr <= unimpl_err;
                    vpd_err_write_protect      <= wp_err;
                    if (rd_p0)
                        vpd_cfg_rdata <= (proto_err || !implemented) ? '0
                                                                      : mem[idx_p0[AW-1:0]];
                end
                DONE: begin
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (!cfg_vpd_rden && !cfg_vpd_wren)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign vpd_busy = (state != IDLE);

endmodule

// File: tb/tb_vpd_ctrl.sv
// Self-checking bench for vpd_ctrl: table vectors, hand-written corner sequences and
// randomized transactions checked against a word-array reference model.
module tb_vpd_ctrl;

    localparam int VW = 512;
    localparam int WP = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [14:0] cfg_vpd_addr;
    logic        cfg_vpd_wren;
    logic [31:0] cfg_vpd_wdata;
    logic        cfg_vpd_rden;
    logic        vpd_wp_override;
    logic [31:0] vpd_cfg_rdata;
    logic        vpd_cfg_done;
    logic        vpd_err_unimplemented_addr;
    logic        vpd_err_write_protect;
    logic        vpd_err_protocol;
    logic        vpd_busy;

    vpd_ctrl #(.VPD_WORDS(VW), .WP_WORDS(WP)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .cfg_vpd_addr               (cfg_vpd_addr),
        .cfg_vpd_wren               (cfg_vpd_wren),
        .cfg_vpd_wdata              (cfg_vpd_wdata),
        .cfg_vpd_rden               (cfg_vpd_rden),
        .vpd_wp_override            (vpd_wp_override),
        .vpd_cfg_rdata              (vpd_cfg_rdata),
        .vpd_cfg_done               (vpd_cfg_done),
        .vpd_err_unimplemented_addr (vpd_err_unimplemented_addr),
        .vpd_err_write_protect      (vpd_err_write_protect),
        .vpd_err_protocol           (vpd_err_protocol),
        .vpd_busy                   (vpd_busy)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_mem [VW];
    logic [31:0] model_rdata;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [14:0] addr;
        logic [31:0] wd;
        logic        ovr;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_err;   // {protocol, unimplemented, write_protect}
    } vec_t;

    vec_t vt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: one access against a flat word array.
    function automatic void model_step(input logic rd, input logic wr, input logic [14:0] addr,
                                       input logic [31:0] wd, input logic ovr,
                                       output logic [31:0] er, output logic [2:0] ee);
        int  w;
        bit  proto, unimpl, wpv;
        w      = int'(addr[14:2]);
        proto  = rd && wr;
        unimpl = !proto && (addr[1:0] != 2'b00 || w >= VW);
        wpv    = !proto && !unimpl && wr && (w < WP) && !ovr;
        ee     = {proto, unimpl, wpv};
        if (proto)
            model_rdata = 32'h0;
        else if (rd)
            model_rdata = unimpl ? 32'h0 : model_mem[w];
        if (wr && !rd && !unimpl && !wpv)
            model_mem[w] = wd;
        er = model_rdata;
    endfunction

    // Called right after a negedge; returns right after a negedge with the request released.
    task automatic txn(input logic rd, input logic wr, input logic [14:0] addr,
                       input logic [31:0] wd, input logic ovr, input int hold,
                       input string tag, output logic [31:0] got_rd, output logic [2:0] got_err);
        int k;
        int extra;
        bit seen;
        cfg_vpd_rden    = rd;
        cfg_vpd_wren    = wr;
        cfg_vpd_addr    = addr;
        cfg_vpd_wdata   = wd;
        vpd_wp_override = ovr;
        seen = 0;
        k    = 0;
        while (!seen && k < 8) begin
            @(negedge clock);
            k++;
            if (k == 1) begin
                cfg_vpd_addr    = 15'($urandom);
                cfg_vpd_wdata   = $urandom;
                vpd_wp_override = 1'($urandom);
            end
            if (vpd_cfg_done) seen = 1;
        end
        check({tag, " latency"}, 32'(k), 32'd2);
        got_rd  = vpd_cfg_rdata;
        got_err = {vpd_err_protocol, vpd_err_unimplemented_addr, vpd_err_write_protect};
        extra = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (vpd_cfg_done) extra++;
        end
        check({tag, " extra done"}, 32'(extra), 32'd0);
        check({tag, " busy held"}, 32'(vpd_busy), 32'd1);
        cfg_vpd_rden = 1'b0;
        cfg_vpd_wren = 1'b0;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (vpd_busy && k < 4);
        check({tag, " busy released"}, 32'(vpd_busy), 32'd0);
    endtask

    task automatic model_txn(input logic rd, input logic wr, input logic [14:0] addr,
                             input logic [31:0] wd, input logic ovr, input int hold,
                             input string tag);
        logic [31:0] got_rd, er;
        logic [2:0]  got_err, ee;
        model_step(rd, wr, addr, wd, ovr, er, ee);
        txn(rd, wr, addr, wd, ovr, hold, tag, got_rd, got_err);
        check({tag, " rdata"}, got_rd, er);
        check({tag, " err"}, 32'(got_err), 32'(ee));
    endtask

    initial begin
        logic [31:0] got_rd, er;
        logic [2:0]  got_err, ee;
        logic [14:0] ra;
        logic        rrd, rwr;

        vt[0]  = '{1'b0, 1'b1, 15'h0400, 32'hDEADBEEF, 1'b0, 32'h00000000, 3'b000};
        vt[1]  = '{1'b1, 1'b0, 15'h0400, 32'h0,        1'b0, 32'hDEADBEEF, 3'b000};
        vt[2]  = '{1'b1, 1'b0, 15'h0402, 32'h0,        1'b0, 32'h00000000, 3'b010};
        vt[3]  = '{1'b1, 1'b0, 15'h0800, 32'h0,        1'b0, 32'h00000000, 3'b010};
        vt[4]  = '{1'b0, 1'b1, 15'h0010, 32'h12345678, 1'b0, 32'h00000000, 3'b001};
        vt[5]  = '{1'b1, 1'b0, 15'h0010, 32'h0,        1'b0, 32'hC0DE0004, 3'b000};
        vt[6]  = '{1'b0, 1'b1, 15'h0010, 32'h12345678, 1'b1, 32'hC0DE0004, 3'b000};
        vt[7]  = '{1'b1, 1'b0, 15'h0010, 32'h0,        1'b0, 32'h12345678, 3'b000};
        vt[8]  = '{1'b1, 1'b1, 15'h0014, 32'hFFFFFFFF, 1'b1, 32'h00000000, 3'b100};
        vt[9]  = '{1'b1, 1'b0, 15'h0014, 32'h0,        1'b0, 32'hC0DE0005, 3'b000};
        vt[10] = '{1'b0, 1'b1, 15'h0802, 32'h11111111, 1'b1, 32'hC0DE0005, 3'b010};
        vt[11] = '{1'b0, 1'b1, 15'h00FC, 32'h22222222, 1'b0, 32'hC0DE0005, 3'b001};
        vt[12] = '{1'b0, 1'b1, 15'h0100, 32'h0BADF00D, 1'b0, 32'hC0DE0005, 3'b000};
        vt[13] = '{1'b1, 1'b0, 15'h0100, 32'h0,        1'b0, 32'h0BADF00D, 3'b000};
        vt[14] = '{1'b1, 1'b1, 15'h0803, 32'h0,        1'b0, 32'h00000000, 3'b100};
        vt[15] = '{1'b1, 1'b0, 15'h7FFC, 32'h0,        1'b0, 32'h00000000, 3'b010};

        reset           = 1'b1;
        cfg_vpd_addr    = '0;
        cfg_vpd_wren    = 1'b0;
        cfg_vpd_wdata   = '0;
        cfg_vpd_rden    = 1'b0;
        vpd_wp_override = 1'b0;
        model_rdata     = 32'h0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset rdata", vpd_cfg_rdata, 32'h0);
        check("reset flags", 32'({vpd_cfg_done, vpd_err_protocol, vpd_err_unimplemented_addr,
                                  vpd_err_write_protect, vpd_busy}), 32'h0);

        for (int i = 0; i < VW; i++)
            model_txn(1'b0, 1'b1, 15'(i << 2), 32'hC0DE0000 | 32'(i), 1'b1, 0, "preload");

        for (int i = 0; i < 16; i++) begin
            model_step(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].ovr, er, ee);
            txn(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].ovr, 1,
                $sformatf("vec%0d", i), got_rd, got_err);
            check($sformatf("vec%0d rdata", i), got_rd, vt[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(got_err), 32'(vt[i].exp_err));
        end

        // Held request: one done per request, second done after a one-cycle release.
        model_txn(1'b1, 1'b0, 15'h0400, 32'h0, 1'b0, 10, "hold1");
        model_txn(1'b1, 1'b0, 15'h0010, 32'h0, 1'b0, 10, "hold2");

        // Reset landing in the access cycle of a write.
        cfg_vpd_wren    = 1'b1;
        cfg_vpd_addr    = 15'h0014;
        cfg_vpd_wdata   = 32'hA5A5A5A5;
        vpd_wp_override = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst-access rdata", vpd_cfg_rdata, 32'h0);
        check("rst-access flags", 32'({vpd_cfg_done, vpd_err_protocol, vpd_err_unimplemented_addr,
                                       vpd_err_write_protect, vpd_busy}), 32'h0);
        reset        = 1'b0;
        cfg_vpd_wren = 1'b0;
        model_rdata  = 32'h0;
        @(negedge clock);
        check("rst-access no done", 32'(vpd_cfg_done), 32'h0);
        model_txn(1'b1, 1'b0, 15'h0014, 32'h0, 1'b0, 1, "rst-readback");

        for (int i = 0; i < 300; i++) begin
            rrd = 1'($urandom);
            rwr = !rrd;
            if ($urandom_range(0, 9) == 0) begin
                rrd = 1'b1;
                rwr = 1'b1;
            end
            case ($urandom_range(0, 3))
                0:       ra = 15'($urandom);
                1:       ra = 15'($urandom_range(0, 2 * WP - 1) << 2);
                default: ra = 15'($urandom_range(0, 16) << 2);
            endcase
            model_txn(rrd, rwr, ra, $urandom, 1'($urandom), $urandom_range(0, 3), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
